// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths plus S-box scheduler state and arbitration encodings
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } sched_state_e;

    typedef enum logic {
        RR_STATE = 1'b0,
        RR_KEY   = 1'b1
    } rr_side_e;

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - combinational AES forward S-box, one byte in, one byte out
module sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_byte
);

    localparam logic [BYTE_W-1:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TBL[in_byte];

endmodule

// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - time-shared S-box scheduler serving state SubBytes and key SubWord
// LANES bytes are substituted per cycle in place in a work buffer; results publish only on the last beat.
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [STATE_W-1:0] st_data,
    output logic               st_done,
    output logic [STATE_W-1:0] st_result,
    input  logic               kw_valid,
    output logic               kw_ready,
    input  logic [WORD_W-1:0]  kw_data,
    output logic               kw_done,
    output logic [WORD_W-1:0]  kw_result
);

    localparam logic [3:0] ST_LAST = 4'(16 / LANES - 1);
    localparam logic [3:0] KW_LAST = 4'(4 / LANES - 1);

    sched_state_e       state_q, state_d;
    rr_side_e           rr_q, rr_d;
    logic [STATE_W-1:0] buf_q, buf_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               st_done_q, st_done_d;
    logic               kw_done_q, kw_done_d;
    logic [STATE_W-1:0] st_result_q, st_result_d;
    logic [WORD_W-1:0]  kw_result_q, kw_result_d;
    logic               grant_kw;

    logic [3:0]        lane_idx [LANES];
    logic [BYTE_W-1:0] lane_in  [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
        assign lane_in[l]  = buf_q[{lane_idx[l], 3'b000} +: BYTE_W];
        sbox u_sbox (
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        st_done_d   = 1'b0;
        kw_done_d   = 1'b0;
        st_result_d = st_result_q;
        kw_result_d = kw_result_q;
        grant_kw    = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_valid || kw_valid) begin
                    // On a tie the rr side wins; rr always ends up on the side that was not served.
                    grant_kw = (st_valid && kw_valid) ? (rr_q == RR_KEY) : kw_valid;
                    cnt_d    = '0;
                    if (grant_kw) begin
                        state_d = KW_RUN;
                        rr_d    = RR_STATE;
                        buf_d   = {{(STATE_W - WORD_W){1'b0}}, kw_data};
                    end else begin
                        state_d = ST_RUN;
                        rr_d    = RR_KEY;
                        buf_d   = st_data;
                    end
                end
            end
            ST_RUN, KW_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    buf_d[{lane_idx[l], 3'b000} +: BYTE_W] = lane_out[l];
                end
                cnt_d = cnt_q + 4'd1;
                if (state_q == ST_RUN && cnt_q == ST_LAST) begin
                    st_result_d = buf_d;
                    st_done_d   = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end
                if (state_q == KW_RUN && cnt_q == KW_LAST) begin
                    kw_result_d = buf_d[WORD_W-1:0];
                    kw_done_d   = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= RR_KEY;
            buf_q       <= '0;
            cnt_q       <= '0;
            st_done_q   <= 1'b0;
            kw_done_q   <= 1'b0;
            st_result_q <= '0;
            kw_result_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            st_done_q   <= st_done_d;
            kw_done_q   <= kw_done_d;
            st_result_q <= st_result_d;
            kw_result_q <= kw_result_d;
        end
    end

    assign st_ready  = (state_q == IDLE);
    assign kw_ready  = (state_q == IDLE);
    assign st_done   = st_done_q;
    assign kw_done   = kw_done_q;
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb/tb_sbox_share_ctrl.sv - self-checking bench for sbox_share_ctrl at LANES = 4, 2 and 1
module tb_sbox_share_ctrl;

    localparam int LANES_OF [3] = '{4, 2, 1};
    localparam int ST_LAT   [3] = '{4, 8, 16};
    localparam int KW_LAT   [3] = '{1, 2, 4};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   st_valid, kw_valid;
    logic [127:0] st_data [3];
    logic [31:0]  kw_data [3];
    logic [2:0]   st_ready_w, kw_ready_w, st_done_w, kw_done_w;
    logic [127:0] st_res_w [3];
    logic [31:0]  kw_res_w [3];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  cmp_en = 1'b0;

    bit [7:0] sb_tab [256];

    bit           m_busy    [3];
    bit           m_kw_side [3];
    bit           m_rr_key  [3];
    int           m_rem     [3];
    logic [127:0] m_pend    [3];
    logic [127:0] e_st_res  [3];
    logic [31:0]  e_kw_res  [3];
    bit           e_st_done [3];
    bit           e_kw_done [3];

    sbox_share_ctrl #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid[0]), .st_ready(st_ready_w[0]), .st_data(st_data[0]),
        .st_done(st_done_w[0]), .st_result(st_res_w[0]),
        .kw_valid(kw_valid[0]), .kw_ready(kw_ready_w[0]), .kw_data(kw_data[0]),
        .kw_done(kw_done_w[0]), .kw_result(kw_res_w[0])
    );
    sbox_share_ctrl #(.LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid[1]), .st_ready(st_ready_w[1]), .st_data(st_data[1]),
        .st_done(st_done_w[1]), .st_result(st_res_w[1]),
        .kw_valid(kw_valid[1]), .kw_ready(kw_ready_w[1]), .kw_data(kw_data[1]),
        .kw_done(kw_done_w[1]), .kw_result(kw_res_w[1])
    );
    sbox_share_ctrl #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid[2]), .st_ready(st_ready_w[2]), .st_data(st_data[2]),
        .st_done(st_done_w[2]), .st_result(st_res_w[2]),
        .kw_valid(kw_valid[2]), .kw_ready(kw_ready_w[2]), .kw_data(kw_data[2]),
        .kw_done(kw_done_w[2]), .kw_result(kw_res_w[2])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lanes=%0d: got %h expected %h", nm, LANES_OF[k], act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_tab[d[8*i +: 8]];
        return r;
    endfunction

    // Reference S-box from its definition: GF(2^8) inverse followed by the affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    end

    // Transaction-level model: one job at a time, done N edges after the accepting edge.
    initial begin
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_rr_key[k] = 1; m_rem[k] = 0; m_kw_side[k] = 0; m_pend[k] = '0;
            e_st_res[k] = '0; e_kw_res[k] = '0; e_st_done[k] = 0; e_kw_done[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    m_busy[k] = 0; m_rr_key[k] = 1; m_rem[k] = 0;
                    e_st_res[k] = '0; e_kw_res[k] = '0; e_st_done[k] = 0; e_kw_done[k] = 0;
                end else begin
                    e_st_done[k] = 0;
                    e_kw_done[k] = 0;
                    if (m_busy[k]) begin
                        m_rem[k]--;
                        if (m_rem[k] == 0) begin
                            m_busy[k] = 0;
                            if (m_kw_side[k]) begin
                                e_kw_res[k] = m_pend[k][31:0];
                                e_kw_done[k] = 1;
                            end else begin
                                e_st_res[k] = m_pend[k];
                                e_st_done[k] = 1;
                            end
                        end
                    end else if (st_valid[k] || kw_valid[k]) begin
                        m_kw_side[k] = (st_valid[k] && kw_valid[k]) ? m_rr_key[k] : kw_valid[k];
                        m_rr_key[k]  = !m_kw_side[k];
                        m_busy[k]    = 1;
                        m_rem[k]     = (m_kw_side[k] ? 4 : 16) / LANES_OF[k];
                        m_pend[k]    = m_kw_side[k] ? sub_state({96'h0, kw_data[k]}) : sub_state(st_data[k]);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("st_ready", k, 128'(st_ready_w[k]), 128'(!m_busy[k]));
                chk("kw_ready", k, 128'(kw_ready_w[k]), 128'(!m_busy[k]));
                chk("st_done", k, 128'(st_done_w[k]), 128'(e_st_done[k]));
                chk("kw_done", k, 128'(kw_done_w[k]), 128'(e_kw_done[k]));
                chk("st_result", k, st_res_w[k], e_st_res[k]);
                chk("kw_result", k, 128'(kw_res_w[k]), 128'(e_kw_res[k]));
            end
        end
    end

    task automatic run_req(input int k, input bit is_kw, input logic [127:0] d,
                           input logic [127:0] exp_res, input string nm);
        int  t;
        int  lat;
        bit  other;
        t = 0;
        if (is_kw) begin kw_data[k] = d[31:0]; kw_valid[k] = 1'b1; end
        else begin st_data[k] = d; st_valid[k] = 1'b1; end
        while (!st_ready_w[k] && t < 50) begin @(posedge clk); #2; t++; end
        chk({nm, "_accept_wait"}, k, 128'(t < 50), 128'(1));
        @(posedge clk); #2;
        st_valid[k] = 1'b0;
        kw_valid[k] = 1'b0;
        lat = 0;
        other = 0;
        while (!(is_kw ? kw_done_w[k] : st_done_w[k]) && lat < 40) begin
            @(posedge clk); #2;
            lat++;
            if (is_kw ? st_done_w[k] : kw_done_w[k]) other = 1;
        end
        chk({nm, "_latency"}, k, 128'(lat), 128'(is_kw ? KW_LAT[k] : ST_LAT[k]));
        chk({nm, "_result"}, k, is_kw ? 128'(kw_res_w[k]) : st_res_w[k], exp_res);
        chk({nm, "_other_done"}, k, 128'(other), 128'(0));
    endtask

    task automatic tie_seq(input int k);
        int kwn, stn, kw_t1, kw_t2, st_t;
        logic [31:0] first_kw;
        kwn = KW_LAT[k]; stn = ST_LAT[k];
        kw_t1 = 0; kw_t2 = 0; st_t = 0; first_kw = '0;
        st_data[k] = 128'h0; kw_data[k] = 32'hcf4f3c09;
        st_valid[k] = 1'b1; kw_valid[k] = 1'b1;
        for (int t = 1; t <= 2 * kwn + stn + 4; t++) begin
            @(posedge clk); #2;
            if (t == 1) kw_data[k] = 32'h0;
            if (t == kwn + 2) st_valid[k] = 1'b0;
            if (t == kwn + stn + 3) kw_valid[k] = 1'b0;
            if (kw_done_w[k]) begin
                if (kw_t1 == 0) begin kw_t1 = t; first_kw = kw_res_w[k]; end
                else kw_t2 = t;
            end
            if (st_done_w[k]) st_t = t;
        end
        chk("tie_key_first_cycle", k, 128'(kw_t1), 128'(1 + kwn));
        chk("tie_key_first_result", k, 128'(first_kw), 128'(32'h8a84eb01));
        chk("tie_state_cycle", k, 128'(st_t), 128'(kwn + 2 + stn));
        chk("tie_state_result", k, st_res_w[k], {16{8'h63}});
        chk("tie_key_second_cycle", k, 128'(kw_t2), 128'(2 * kwn + stn + 3));
        chk("tie_key_second_result", k, 128'(kw_res_w[k]), 128'(32'h63636363));
    endtask

    task automatic dir_seq(input int k);
        run_req(k, 1'b0, 128'h0, {16{8'h63}}, "st_zero");
        run_req(k, 1'b1, 128'(32'hcf4f3c09), 128'(32'h8a84eb01), "kw_vec");
        run_req(k, 1'b0, {4{32'h01ff5300}}, {4{32'h7c16ed63}}, "st_pattern");
        chk("kw_kept", k, 128'(kw_res_w[k]), 128'(32'h8a84eb01));
    endtask

    initial begin
        bit [7:0] pin_in  [8];
        bit [7:0] pin_out [8];
        pin_in  = '{8'h00, 8'h53, 8'hff, 8'h01, 8'hcf, 8'h4f, 8'h3c, 8'h09};
        pin_out = '{8'h63, 8'hed, 8'h16, 8'h7c, 8'h8a, 8'h84, 8'heb, 8'h01};
        rst_n = 1'b0;
        st_valid = '0;
        kw_valid = '0;
        for (int k = 0; k < 3; k++) begin st_data[k] = '0; kw_data[k] = '0; end
        #7 cmp_en = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) chk("ref_sbox_pin", 0, 128'(sb_tab[pin_in[i]]), 128'(pin_out[i]));
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", k, 128'(st_ready_w[k] & kw_ready_w[k]), 128'(1));
            chk("reset_results", k, st_res_w[k] | 128'(kw_res_w[k]), 128'h0);
        end

        fork
            tie_seq(0);
            tie_seq(1);
            tie_seq(2);
        join
        fork
            dir_seq(0);
            dir_seq(1);
            dir_seq(2);
        join

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                st_valid[k] = ($urandom_range(0, 2) == 0);
                kw_valid[k] = ($urandom_range(0, 2) == 0);
                st_data[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                kw_data[k]  = $urandom();
            end
            @(posedge clk); #2;
        end
        st_valid = '0;
        kw_valid = '0;
        repeat (20) @(posedge clk);
        #2;

        for (int k = 0; k < 3; k++) st_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        st_valid = 3'b111;
        @(posedge clk); #2;
        st_valid = '0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("abort_st_result", k, st_res_w[k], 128'h0);
            chk("abort_kw_result", k, 128'(kw_res_w[k]), 128'h0);
            chk("abort_ready", k, 128'(st_ready_w[k]), 128'(1));
            chk("abort_done", k, 128'(st_done_w[k] | kw_done_w[k]), 128'(0));
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        fork
            run_req(0, 1'b0, {4{32'h01ff5300}}, {4{32'h7c16ed63}}, "after_reset");
            run_req(1, 1'b0, {4{32'h01ff5300}}, {4{32'h7c16ed63}}, "after_reset");
            run_req(2, 1'b0, {4{32'h01ff5300}}, {4{32'h7c16ed63}}, "after_reset");
        join
        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
